vga_timing: RTL

Generates 640x480 @ ~60 Hz VGA raster timing from the 25.125 MHz pixel clock produced by `mypll`. It sits directly downstream of the PLL and upstream of the pattern/pixel generator. It provides active-low sync pulses, an active-video flag, the current pixel coordinate, and line/frame start strobes. All outputs are registered, so the display path sees glitch-free sync.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_timing.sv | 74 +++++++
 2 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing shared by the timing generator and pixel generator.
package vga_pkg;
    localparam int COORD_W  = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    // Half-open window test used for sync decode: lo <= v < hi.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction
endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: free-running h/v counters decoded into registered sync/valid/coords.
// Latency: outputs describe the counter values held one edge earlier.
// Backpressure: none; the raster runs every pixel clock.
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        valid,
    output logic [vga_pkg::COORD_W-1:0] col,
    output logic [vga_pkg::COORD_W-1:0] row,
    output logic                        line_start,
    output logic                        frame_start
);
    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_total_check
        $error("vga_timing: H/V totals do not fit the 10-bit counters");
    end

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t hcount;
    coord_t vcount;

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            valid       <= 1'b0;
            col         <= '0;
            row         <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end

            // Decode the pre-edge counters so every output shares one cycle of latency.
            hsync       <= !in_window(hcount, HS_START, HS_END);
            vsync       <= !in_window(vcount, VS_START, VS_END);
            valid       <= (hcount < H_VIS) && (vcount < V_VIS);
            col         <= hcount;
            row         <= vcount;
            line_start  <= (hcount == '0);
            frame_start <= (hcount == '0) && (vcount == '0);
        end
    end
endmodule
